// File: rtl/apb_master_arbiter.sv
// ============================================================================
//  Module      : apb_master_arbiter
//  Description : Round-robin arbiter plus APB master sequencer. Shares one APB
//                bus among NUM_REQ requesters, one single-word command at a
//                time, with an ACCESS-phase timeout so a hung slave cannot
//                hold the bus forever.
//  Ports       : clk, rstn (sync, active-low)
//                req_valid/req_write/req_addr/req_wdata : packed commands
//                req_ready  : one-hot accept pulse (combinational, IDLE only)
//                rsp_valid/rsp_rdata/rsp_err : one-cycle completion
//                addr/sel/penable/write/wdata : APB master outputs
//                rdata/ready/slave_error_in   : APB slave returns
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

`default_nettype none

module apb_master_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = `APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = `APB_DATA_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [ADDR_WIDTH-1:0]            addr,
    output logic                             sel,
    output logic                             penable,
    output logic                             write,
    output logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH-1:0]            rdata,
    input  logic                             ready,
    input  logic                             slave_error_in
);

    localparam int                 c_idx_w     = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_one       = NUM_REQ'(1);
    localparam logic [7:0]         c_wait_last = 8'(TIMEOUT - 1);
    localparam logic [c_idx_w-1:0] c_last_req  = c_idx_w'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [c_idx_w-1:0]      r_rr_ptr;
    logic [c_idx_w-1:0]      r_gnt;
    logic [c_idx_w-1:0]      w_gnt;
    logic [7:0]              r_wait;
    logic                    w_done;
    logic                    w_timeout;
    logic [NUM_REQ-1:0]      w_req_ready;

    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_write;
    logic                    r_sel;
    logic                    r_penable;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    // First valid requester at or above ptr, wrapping past NUM_REQ-1 to 0.
    function automatic logic [c_idx_w-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                   input logic [c_idx_w-1:0] ptr);
        logic [c_idx_w-1:0] pick;
        logic [c_idx_w-1:0] idx;
        logic               found;
        int                 sum;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = sum[c_idx_w-1:0];
            if (!found && v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_next_state = r_state;
        w_gnt        = rr_pick(req_valid, r_rr_ptr);
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        w_req_ready  = '0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_req_ready  = c_one << w_gnt;
                    w_next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                if (ready) begin
                    w_done = 1'b1;
                end else if (r_wait == c_wait_last) begin
                    // TIMEOUT consecutive ready-low cycles: abandon the slave.
                    w_done    = 1'b1;
                    w_timeout = 1'b1;
                end
                if (w_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_wait      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_sel       <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_gnt   <= w_gnt;
                        r_addr  <= req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata <= req_wdata[w_gnt*DATA_WIDTH +: DATA_WIDTH];
                        r_write <= req_write[w_gnt];
                        r_sel   <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                end
                S_ACCESS: begin
                    if (w_done) begin
                        r_sel       <= 1'b0;
                        r_penable   <= 1'b0;
                        r_wait      <= '0;
                        r_rsp_valid <= c_one << r_gnt;
                        // Writes and timed-out transfers return zero data.
                        r_rsp_rdata <= (w_timeout || r_write) ? '0 : rdata;
                        r_rsp_err   <= w_timeout ? 1'b1 : slave_error_in;
                        r_rr_ptr    <= (r_gnt == c_last_req) ? '0 : r_gnt + 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                    r_sel     <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign addr      = r_addr;
    assign sel       = r_sel;
    assign penable   = r_penable;
    assign write     = r_write;
    assign wdata     = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// ============================================================================
//  Module      : tb_apb_master_arbiter
//  Description : Directed self-checking bench for apb_master_arbiter
//                (NUM_REQ=4, 32-bit address/data, TIMEOUT=16). Inputs change
//                at the falling edge, outputs are checked 1 time unit later.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic [AW-1:0]      addr;
    logic               sel;
    logic               penable;
    logic               write;
    logic [DW-1:0]      wdata;
    logic [DW-1:0]      rdata;
    logic               ready;
    logic               slave_error_in;

    int n_cmp = 0;
    int n_err = 0;

    apb_master_arbiter #(
        .NUM_REQ    (NREQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (16)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .addr           (addr),
        .sel            (sel),
        .penable        (penable),
        .write          (write),
        .wdata          (wdata),
        .rdata          (rdata),
        .ready          (ready),
        .slave_error_in (slave_error_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] wr_pat;
        int              g;

        rstn           = 1'b0;
        req_valid      = '0;
        req_write      = '0;
        req_addr       = '0;
        req_wdata      = '0;
        rdata          = '0;
        ready          = 1'b0;
        slave_error_in = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk); #1;
        chk("rst_sel",       64'(sel),       64'h0);
        chk("rst_penable",   64'(penable),   64'h0);
        chk("rst_addr",      64'(addr),      64'h0);
        chk("rst_wdata",     64'(wdata),     64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        @(negedge clk); rstn = 1'b1;

        // ---------------- single read, requester 2 (rr_ptr=0) ----------------
        @(negedge clk);
        req_valid = 4'b0100; req_write = 4'b0000;
        req_addr[2*AW +: AW] = 32'h40;
        #1 chk("rd_req_ready", 64'(req_ready), 64'h4);
        @(negedge clk); req_valid = '0; #1;
        chk("rd_setup_sel",     64'(sel),     64'h1);
        chk("rd_setup_penable", 64'(penable), 64'h0);
        chk("rd_setup_addr",    64'(addr),    64'h40);
        chk("rd_setup_write",   64'(write),   64'h0);
        @(negedge clk); ready = 1'b1; rdata = 32'hDEADBEEF; #1;
        chk("rd_access_penable", 64'(penable), 64'h1);
        @(negedge clk); ready = 1'b0; rdata = '0; #1;
        chk("rd_rsp_valid", 64'(rsp_valid), 64'h4);
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk("rd_rsp_err",   64'(rsp_err),   64'h0);
        chk("rd_idle_sel",  64'(sel),       64'h0);
        @(negedge clk); #1;
        chk("rd_rsp_pulse", 64'(rsp_valid), 64'h0);

        // ---------------- write, requester 1, 3 wait states, slave error ----------------
        @(negedge clk);
        req_valid = 4'b0010; req_write = 4'b0010;
        req_addr[1*AW +: AW]  = 32'h1234;
        req_wdata[1*DW +: DW] = 32'hCAFEF00D;
        #1 chk("wr_req_ready", 64'(req_ready), 64'h2);
        @(negedge clk); req_valid = '0; #1;
        chk("wr_setup_addr",    64'(addr),    64'h1234);
        chk("wr_setup_wdata",   64'(wdata),   64'hCAFEF00D);
        chk("wr_setup_write",   64'(write),   64'h1);
        chk("wr_setup_penable", 64'(penable), 64'h0);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            ready = (w == 3); slave_error_in = (w == 3); rdata = 32'hFFFFFFFF;
            #1;
            chk("wr_access_penable", 64'(penable), 64'h1);
            chk("wr_access_addr",    64'(addr),    64'h1234);
            chk("wr_access_wdata",   64'(wdata),   64'hCAFEF00D);
        end
        @(negedge clk); ready = 1'b0; slave_error_in = 1'b0; #1;
        chk("wr_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("wr_rsp_err",   64'(rsp_err),   64'h1);
        chk("wr_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("wr_idle_penable", 64'(penable), 64'h0);

        // ---------------- timeout, requester 2, requester 3 waiting (rr_ptr=2) ----------------
        @(negedge clk);
        req_valid = 4'b1100; req_write = 4'b0000;
        req_addr[2*AW +: AW] = 32'h80;
        req_addr[3*AW +: AW] = 32'h300;
        #1 chk("to_req_ready", 64'(req_ready), 64'h4);
        @(negedge clk); req_valid = 4'b1000; #1;
        chk("to_setup_req_ready", 64'(req_ready), 64'h0);
        chk("to_setup_addr",      64'(addr),      64'h80);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); #1;
            chk("to_access_penable",   64'(penable),   64'h1);
            chk("to_access_rsp_valid", 64'(rsp_valid), 64'h0);
        end
        @(negedge clk); #1;
        chk("to_rsp_valid",  64'(rsp_valid), 64'h4);
        chk("to_rsp_err",    64'(rsp_err),   64'h1);
        chk("to_rsp_rdata",  64'(rsp_rdata), 64'h0);
        chk("to_penable",    64'(penable),   64'h0);
        chk("to_next_grant", 64'(req_ready), 64'h8);
        @(negedge clk); req_valid = '0; #1;
        chk("to_next_addr", 64'(addr), 64'h300);
        @(negedge clk); ready = 1'b1; rdata = 32'h33; #1;
        @(negedge clk); ready = 1'b0; rdata = '0; #1;
        chk("to_next_rsp_valid", 64'(rsp_valid), 64'h8);
        chk("to_next_rsp_rdata", 64'(rsp_rdata), 64'h33);
        chk("to_next_rsp_err",   64'(rsp_err),   64'h0);

        // ---------------- requester 3 withdraws while 1 holds the bus (rr_ptr=0) ----------------
        @(negedge clk);
        req_valid = 4'b0010; req_addr[1*AW +: AW] = 32'h10;
        #1 chk("wd_req_ready", 64'(req_ready), 64'h2);
        @(negedge clk); req_valid = 4'b1000; #1;
        chk("wd_setup_req_ready", 64'(req_ready), 64'h0);
        @(negedge clk); ready = 1'b1; rdata = 32'h11; #1;
        chk("wd_access_req_ready", 64'(req_ready), 64'h0);
        @(negedge clk); ready = 1'b0; rdata = '0; req_valid = '0; #1;
        chk("wd_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("wd_req_ready_after", 64'(req_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("wd_quiet_rsp_valid", 64'(rsp_valid), 64'h0);
            chk("wd_quiet_req_ready", 64'(req_ready), 64'h0);
            chk("wd_quiet_sel",       64'(sel),       64'h0);
        end

        // ---------------- reset mid-ACCESS (rr_ptr=2, only requester 0 valid) ----------------
        @(negedge clk);
        req_valid = 4'b0001; req_addr[0*AW +: AW] = 32'h500;
        #1 chk("rm_req_ready", 64'(req_ready), 64'h1);
        @(negedge clk); req_valid = '0; #1;
        @(negedge clk); rstn = 1'b0; #1;
        chk("rm_access_penable", 64'(penable), 64'h1);
        @(negedge clk); #1;
        chk("rm_sel",       64'(sel),       64'h0);
        chk("rm_penable",   64'(penable),   64'h0);
        chk("rm_addr",      64'(addr),      64'h0);
        chk("rm_rsp_valid", 64'(rsp_valid), 64'h0);
        @(negedge clk); rstn = 1'b1; #1;
        chk("rm_rsp_valid2", 64'(rsp_valid), 64'h0);
        chk("rm_sel2",       64'(sel),       64'h0);

        // ---------------- all four valid, zero wait: grants 0,1,2,3,0 ----------------
        wr_pat    = 4'b1010;
        req_write = wr_pat;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = 32'h100 + 32'(i * 4);
            req_wdata[i*DW +: DW] = 32'hA0 + 32'(i);
        end
        ready = 1'b1; rdata = 32'h5555AAAA;
        for (int n = 0; n < 5; n++) begin
            g = n % NREQ;
            @(negedge clk); req_valid = 4'b1111; #1;
            if (n > 0) begin
                chk("rr_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << ((n - 1) % NREQ)));
                chk("rr_rsp_rdata", 64'(rsp_rdata),
                    wr_pat[(n - 1) % NREQ] ? 64'h0 : 64'h5555AAAA);
            end
            chk("rr_req_ready", 64'(req_ready), 64'(4'b0001 << g));
            @(negedge clk); #1;
            chk("rr_addr",  64'(addr),  64'(32'h100 + 32'(g * 4)));
            chk("rr_wdata", 64'(wdata), 64'(32'hA0 + 32'(g)));
            chk("rr_write", 64'(write), 64'(wr_pat[g]));
            chk("rr_setup_penable", 64'(penable), 64'h0);
            @(negedge clk); #1;
            chk("rr_access_penable", 64'(penable), 64'h1);
        end
        @(negedge clk); req_valid = '0; #1;
        chk("rr_last_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("rr_last_rsp_rdata", 64'(rsp_rdata), 64'h5555AAAA);
        chk("rr_last_req_ready", 64'(req_ready), 64'h0);
        ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
